// File: rtl/traceback_mem.sv
// Viterbi survivor traceback memory.
// Collects one survivor stage per accepted input (each stage holds, for every
// trellis state, the index of its predecessor), then walks the trellis
// backwards from a supplied start state, emitting one decoded bit per
// accepted output transfer, newest stage first.
module traceback_mem #(
  parameter  int K      = 3,
  parameter  int DEPTH  = 8,
  localparam int ST_W   = K - 1,
  localparam int NUM_ST = 1 << (K - 1),
  localparam int IW     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_ST*ST_W-1:0] in_surv,
  input  logic [ST_W-1:0]        start_st,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_bit,
  output logic [IW-1:0]          out_idx,
  output logic                   out_last,
  output logic                   busy
);

  typedef enum logic {
    FILL,
    TRACE
  } state_t;

  localparam logic [IW:0] CNT_LAST = (IW + 1)'(DEPTH - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [IW:0]             cnt;
  logic [IW-1:0]           rd_ptr;
  logic [ST_W-1:0]         cur_st;
  logic [NUM_ST*ST_W-1:0]  mem [DEPTH];
  logic [NUM_ST*ST_W-1:0]  rd_word;
  logic [ST_W-1:0]         pred;
  logic                    wr_en;
  logic                    out_fire;

  assign wr_en    = (state == FILL) && in_valid;
  assign out_fire = (state == TRACE) && out_ready;

  // Survivor storage: written only while filling, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[cnt[IW-1:0]] <= in_surv;
    end
  end

  // Predecessor lookup: select the slice of the current stage owned by cur_st.
  always_comb begin
    rd_word = mem[rd_ptr];
    pred    = '0;
    for (int unsigned j = 0; j < NUM_ST; j++) begin
      if (cur_st == ST_W'(j)) begin
        pred = rd_word[j*ST_W +: ST_W];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: full window or a flush on a non-empty window starts traceback.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (in_valid && (cnt == CNT_LAST)) begin
          state_nxt = TRACE;
        end else if (flush && (in_valid || (cnt != '0))) begin
          state_nxt = TRACE;
        end
      end
      TRACE: begin
        if (out_ready && (rd_ptr == '0)) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Datapath: fill counter, read pointer and traceback state.
  // On entry to TRACE the newest valid entry is cnt-1 before the write, or
  // cnt itself when a stage is written on the same edge; both the full-window
  // case and flush-with-write collapse onto the second form.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= '0;
      rd_ptr <= '0;
      cur_st <= '0;
    end else begin
      if (wr_en) begin
        cnt <= cnt + (IW + 1)'(1);
      end
      if ((state == FILL) && (state_nxt == TRACE)) begin
        cur_st <= start_st;
        rd_ptr <= in_valid ? cnt[IW-1:0] : (cnt[IW-1:0] - IW'(1));
      end
      if (out_fire) begin
        cur_st <= pred;
        if (rd_ptr == '0) begin
          cnt <= '0;
        end else begin
          rd_ptr <= rd_ptr - IW'(1);
        end
      end
    end
  end

  assign in_ready  = (state == FILL);
  assign out_valid = (state == TRACE);
  assign busy      = (state == TRACE);
  assign out_bit   = cur_st[ST_W-1];
  assign out_idx   = rd_ptr;
  assign out_last  = (state == TRACE) && (rd_ptr == '0);

endmodule

// File: doc/traceback_mem.md
TRACEBACK_MEM -- requirements
Module: traceback_mem

Interface
REQ-001 SHALL have parameter K, default 3, meaning code constraint length; derived ST_W = K-1 and NUM_ST = 2^(K-1).
REQ-002 SHALL have parameter DEPTH, default 8, meaning traceback depth in trellis stages (power of two, at least 2); derived IW = clog2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  survivor stage offered.
REQ-006 SHALL have port in_ready  output  1  block accepts a stage this cycle.
REQ-007 SHALL have port in_surv  input  NUM_ST*ST_W  slice j (bits j*ST_W +: ST_W) = predecessor state of state j.
REQ-008 SHALL have port start_st  input  ST_W  traceback start state, sampled on the cycle traceback is entered.
REQ-009 SHALL have port flush  input  1  start traceback early on a partial window.
REQ-010 SHALL have port out_valid  output  1  decoded bit presented.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the decoded bit.
REQ-012 SHALL have port out_bit  output  1  decoded bit = MSB of current traceback state.
REQ-013 SHALL have port out_idx  output  IW  stage index of out_bit, 0 = oldest.
REQ-014 SHALL have port out_last  output  1  marks final bit of the window (out_idx = 0).
REQ-015 SHALL have port busy  output  1  high while in TRACE.

Function
REQ-016 SHALL implement a two-state FSM: FILL (in_ready=1, out_valid=0) and TRACE (in_ready=0, out_valid=1).
REQ-017 SHALL in FILL, on in_valid, store in_surv at stage cnt and increment cnt (width IW+1).
REQ-018 SHALL go to TRACE on the edge where the write makes cnt reach DEPTH, loading cur_st <= start_st and rd_ptr <= DEPTH-1; first out_valid appears the cycle after the last write.
REQ-019 SHALL, on flush in FILL with cnt > 0, go to TRACE over cnt entries (rd_ptr <= cnt-1); flush with cnt = 0 SHALL be ignored.
REQ-020 SHALL, on flush and in_valid in the same FILL cycle, store the stage first and trace over cnt+1 entries.
REQ-021 SHALL ignore flush and in_valid while in TRACE.
REQ-022 SHALL drive out_bit = cur_st[ST_W-1] and out_idx = rd_ptr combinationally from registers.
REQ-023 SHALL, on out_valid and out_ready, update cur_st <= slice cur_st of stage rd_ptr and decrement rd_ptr.
REQ-024 SHALL hold out_bit, out_idx and out_last stable while out_valid=1 and out_ready=0.
REQ-025 SHALL drive out_last = 1 exactly when in TRACE with rd_ptr = 0.
REQ-026 SHALL, on the transfer with out_last=1, return to FILL, clear cnt, and accept a new stage from the next cycle.
REQ-027 SHALL emit bits newest-first (out_idx descending) with no gaps or repeats.
REQ-028 SHALL not require survivor storage to be reset, and SHALL never read stages not written in the current window.

Reset
REQ-029 SHALL, while rst=0 at a clock edge, set state=FILL, cnt=0, rd_ptr=0, cur_st=0, giving in_ready=1, out_valid=0, out_last=0, busy=0, out_bit=0, out_idx=0 from the next cycle.
REQ-030 SHALL, on reset during TRACE, abandon the window and discard any partial output.

Verification (K=3, DEPTH=8)
REQ-031 SHALL cover: rst=0 for 2 cycles -> in_ready=1, out_valid=0, busy=0, out_idx=0.
REQ-032 SHALL cover: 8 stages of in_surv=8'h00, start_st=0, out_ready=1 -> 8 bits all 0, out_idx 7..0, out_last only at idx 0, in_ready=0 for exactly 8 cycles.
REQ-033 SHALL cover: 8 stages of in_surv=8'hAA (every predecessor = 2'b10), start_st=2'b01 -> out_bit sequence 0,1,1,1,1,1,1,1.
REQ-034 SHALL cover: 3 writes then flush (no in_valid) -> out_idx 2,1,0 with out_last on 0; flush with cnt=0 -> no TRACE entry.
REQ-035 SHALL cover: out_ready=0 for 3 cycles at out_idx=5 -> outputs held, then 5,4,...,0 resume with no skip.
REQ-036 SHALL cover: rst=0 at out_idx=4 -> next cycle in_ready=1, out_valid=0; the following 8-stage window decodes correctly.
